// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit. It holds the architectural HI/LO
// registers and runs MULT, MULTU, DIV and DIVU, one iteration per cycle.
// MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Handshake: start is sampled only in IDLE. An accepted start raises busy
// on the same edge. busy stays high until the edge that writes HI/LO. At
// that edge done rises for exactly one cycle. start while busy is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // multiply: {partial, multiplier}; divide: {rem, dividend/quotient}
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_raw;    // original dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_res;  // negate product / quotient
  logic               neg_rem;  // negate remainder (dividend was negative)

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign dbg_state = state;

  // Operand magnitudes for signed ops; the most-negative value maps onto itself,
  // which is its correct unsigned magnitude.
  assign abs_a = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // One shift-add or restoring-divide step, plus the final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, mag_b};
    div_sub   = WIDTH'(div_shift - {1'b0, mag_b});
    if (is_div)
      acc_next = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: IDLE -> RUN on start, WIDTH iterations, one FIX cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (cnt == CW'(WIDTH - 1)) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div      <= op[1];
            a_raw       <= a;
            mag_a       <= abs_a;
            mag_b       <= abs_b;
            neg_res     <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem     <= op[0] & a[WIDTH-1];
            div_by_zero <= op[1] & (b == '0);
            busy        <= 1'b1;
            cnt         <= '0;
            acc         <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_by_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, operating alongside the 32-bit ALU on the same register-file operands a, b.
- Implements MIPS MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes.
- HI/LO drive the MFHI/MFLO writeback path.
- Control sequences through a start/busy/done handshake; the core stalls while busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO are valid
div_by_zero  output  1  last divide had b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state = IDLE; hi = lo = 0; busy = done = div_by_zero = 0.
  - The in-flight operation is discarded.
- States and transitions:
  - IDLE: if start, go to RUN on that edge E0. Latch op, |a| and |b| for signed ops (raw values for unsigned), and the result signs. Set busy = 1. Clear div_by_zero, then set it to (b == 0) if op is a divide.
  - RUN: one iteration per edge, E1..E_WIDTH, counted by an internal counter.
    - Multiply: shift-add, 2*WIDTH-bit accumulator.
    - Divide: restoring; one quotient bit per cycle.
    - After E_WIDTH, go to FIX.
  - FIX: at edge E_{WIDTH+1}, apply sign correction, write hi/lo, set busy = 0, set done = 1, return to IDLE.
  - done is high for exactly the one cycle after E_{WIDTH+1}; it clears at the next edge.
- Latency: start sampled at E0, results visible after E_{WIDTH+1}, i.e. WIDTH+2 edges (34 for WIDTH = 32). busy is high strictly between E0 and E_{WIDTH+1}.
- Multiply result: {hi, lo} = 2*WIDTH-bit product.
  - MULT: product is negated (two's complement over 2*WIDTH bits) when sign(a) XOR sign(b).
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient is negated when sign(a) XOR sign(b); remainder takes the sign of the dividend. Truncation is toward zero.
- Divide by zero (b == 0, either op): lo = all ones, hi = a as originally presented (unsigned raw value, no sign correction). div_by_zero = 1 until the next accepted start or reset. Timing is the same as a normal divide.
- Signed overflow: DIV of the most-negative value by -1 gives lo = 0x80000000, hi = 0, no flag.
- start while busy: ignored, no queueing.
- start while done = 1 (state is IDLE): accepted normally.
- MTHI/MTLO:
  - In IDLE without start, hi_we / lo_we write wdata to hi / lo at the edge. Both may be asserted in the same cycle.
  - While busy: writes are ignored.
  - In IDLE with start also asserted: start wins and the writes are dropped.
- hi/lo hold their values between operations. They are not modified during RUN; intermediate state lives in internal registers only.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> busy high for cycles 1..33; done pulses in cycle 34 only; hi = 0xFFFFFFFE, lo = 0x00000001.
2. MULT a = 0xFFFFFFFD (-3), b = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; then MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
3. DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then DIVU 7/2 -> lo = 3, hi = 1. Then DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
4. DIVU a = 100, b = 0 -> lo = 0xFFFFFFFF, hi = 0x00000064, div_by_zero = 1. Next MULTU 2*3 -> div_by_zero clears at acceptance; hi = 0, lo = 6.
5. Start a DIVU; assert start (new operands), hi_we and lo_we at cycle 10 -> all ignored; original result delivered at cycle 34.
   - Then, in IDLE, assert hi_we with wdata = 0x1234 -> hi = 0x1234 next cycle.
   - Then start + lo_we in the same IDLE cycle -> lo_we dropped; operation runs.
6. Assert reset at cycle 15 of a MULT -> next cycle busy = 0, done = 0, hi = lo = 0; no done pulse follows. A start two cycles later completes normally.
